flb_band_ctrl: RTL

Coarse-band search controller for the FLB loop, running in the `nsh_clk` domain. It measures the `nsh_clk` period count between synchronized reference pulses and binary-searches the 8-bit DCO `band` to hit a target count. On lock it hands the loop to the digital loop filter and switches the synchronizer sample and matrix lags to their operating values. It drives the `band`, `smpl_clk_lag` and `mtrx_clk_lag` inputs of the synchronizer stage.

---
 rtl/flb_band_ctrl.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/flb_band_ctrl.sv
// flb_band_ctrl -- coarse-band search controller for the FLB loop.
//
// Runs entirely in the nsh_clk domain. Measures the number of nsh_clk cycles
// between synchronized reference pulses and binary-searches the 8-bit DCO
// band, MSB first, toward target_cnt. A final verify measurement decides
// between LOCKED (loop filter enabled, operating lags applied) and FAIL.
//
// Optional feature macro: FLB_RELOCK_EN
//   defined   : LOCKED keeps measuring every reference period; LOSS_CNT
//               consecutive out-of-tolerance periods restart the search.
//   undefined : LOCKED is passive until start or rst.
//
// Parameters:
//   SETTLE_REFS  reference pulses skipped after each band change (1..15)
//   LOSS_CNT     consecutive bad periods that count as loss of lock (1..15)
//
// Ports:
//   nsh_clk       in   clock, all logic on rising edge
//   rst           in   synchronous reset, active high
//   start         in   one-cycle search request, accepted in IDLE/LOCKED/FAIL
//   ref_pulse     in   one-cycle synchronized reference edge
//   target_cnt    in   desired cycles per reference period (latched on start)
//   tol           in   lock tolerance in cycles (latched on start)
//   cfg_smpl_lag  in   operating sample lag, used in LOCKED
//   cfg_mtrx_lag  in   operating matrix lag, used in LOCKED
//   band          out  DCO coarse band
//   smpl_clk_lag  out  synchronizer sample lag
//   mtrx_clk_lag  out  synchronizer matrix lag
//   dlf_en        out  loop filter enable, high only in LOCKED
//   busy          out  search or verify in progress
//   locked        out  lock achieved
//   fail          out  search ended without lock (sticky)
//   meas_cnt      out  last completed period measurement
module flb_band_ctrl #(
    parameter int SETTLE_REFS = 4,
    parameter int LOSS_CNT    = 3
) (
    input  logic        nsh_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ref_pulse,
    input  logic [15:0] target_cnt,
    input  logic [7:0]  tol,
    input  logic [1:0]  cfg_smpl_lag,
    input  logic [1:0]  cfg_mtrx_lag,
    output logic [7:0]  band,
    output logic [1:0]  smpl_clk_lag,
    output logic [1:0]  mtrx_clk_lag,
    output logic        dlf_en,
    output logic        busy,
    output logic        locked,
    output logic        fail,
    output logic [15:0] meas_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DECIDE,
        S_LOCKED,
        S_FAIL
    } state_t;

    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_REFS - 1);
    // Counter value one short of saturation: the edge that would take the
    // counter to 16'hFFFF declares the reference lost instead.
    localparam logic [15:0] CNT_SAT_M1  = 16'hFFFE;

    if (SETTLE_REFS < 1 || SETTLE_REFS > 15 || LOSS_CNT < 1 || LOSS_CNT > 15) begin : g_param_check
        $error("flb_band_ctrl: SETTLE_REFS and LOSS_CNT must be in 1..15");
    end

    state_t      state, state_d;
    logic [7:0]  band_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic        verify, verify_d;
    logic [3:0]  settle_cnt, settle_d;
    logic [15:0] cnt, cnt_d;
    logic [15:0] meas_d;
    logic [15:0] tgt_q, tgt_d;
    logic [7:0]  tol_q, tol_d;
    logic [1:0]  smpl_d, mtrx_d;
    logic        dlf_en_d, busy_d, locked_d, fail_d;
    logic        restart;

`ifdef FLB_RELOCK_EN
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);
    logic [3:0]  loss_cnt, loss_d;
`endif

    function automatic logic [16:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    always_comb begin
        state_d   = state;
        band_d    = band;
        bit_idx_d = bit_idx;
        verify_d  = verify;
        settle_d  = settle_cnt;
        cnt_d     = cnt;
        meas_d    = meas_cnt;
        tgt_d     = tgt_q;
        tol_d     = tol_q;
        smpl_d    = smpl_clk_lag;
        mtrx_d    = mtrx_clk_lag;
        dlf_en_d  = dlf_en;
        busy_d    = busy;
        locked_d  = locked;
        fail_d    = fail;
        restart   = 1'b0;
`ifdef FLB_RELOCK_EN
        loss_d    = loss_cnt;
`endif

        // start has priority over everything, including a coincident pulse.
        if (start && (state == S_IDLE || state == S_LOCKED || state == S_FAIL)) begin
            restart = 1'b1;
            tgt_d   = target_cnt;
            tol_d   = tol;
        end else begin
            case (state)
                S_SETTLE: begin
                    if (ref_pulse) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_d = '0;
                            cnt_d    = '0;
                            state_d  = S_MEASURE;
                        end else begin
                            settle_d = settle_cnt + 4'd1;
                        end
                    end
                end

                S_MEASURE: begin
                    if (ref_pulse) begin
                        meas_d  = cnt + 16'd1;
                        cnt_d   = '0;
                        state_d = S_DECIDE;
                    end else if (cnt == CNT_SAT_M1) begin
                        cnt_d   = 16'hFFFF;
                        meas_d  = 16'hFFFF;
                        fail_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FAIL;
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end

                S_DECIDE: begin
                    // Keep counting through DECIDE so a relock build measures
                    // the first LOCKED period from the verify pulse onward.
                    cnt_d = cnt + 16'd1;
                    if (!verify) begin
                        if (meas_cnt > tgt_q)
                            band_d[bit_idx] = 1'b0;
                        if (bit_idx != 3'd0) begin
                            band_d[bit_idx - 3'd1] = 1'b1;
                            bit_idx_d              = bit_idx - 3'd1;
                        end else begin
                            verify_d = 1'b1;
                        end
                        state_d = S_SETTLE;
                    end else if (abs_diff(meas_cnt, tgt_q) <= {9'd0, tol_q}) begin
                        locked_d = 1'b1;
                        dlf_en_d = 1'b1;
                        busy_d   = 1'b0;
                        smpl_d   = cfg_smpl_lag;
                        mtrx_d   = cfg_mtrx_lag;
                        state_d  = S_LOCKED;
`ifdef FLB_RELOCK_EN
                        loss_d   = '0;
`endif
                    end else begin
                        fail_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FAIL;
                    end
                end

                S_LOCKED: begin
                    smpl_d = cfg_smpl_lag;
                    mtrx_d = cfg_mtrx_lag;
`ifdef FLB_RELOCK_EN
                    if (ref_pulse) begin
                        meas_d = cnt + 16'd1;
                        cnt_d  = '0;
                        if (abs_diff(cnt + 16'd1, tgt_q) <= {9'd0, tol_q})
                            loss_d = '0;
                        else if (loss_cnt == LOSS_LAST)
                            restart = 1'b1;
                        else
                            loss_d = loss_cnt + 4'd1;
                    end else if (cnt == CNT_SAT_M1) begin
                        cnt_d    = 16'hFFFF;
                        meas_d   = 16'hFFFF;
                        fail_d   = 1'b1;
                        busy_d   = 1'b0;
                        locked_d = 1'b0;
                        dlf_en_d = 1'b0;
                        state_d  = S_FAIL;
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
`endif
                end

                S_IDLE, S_FAIL: ;

                default: state_d = S_IDLE;
            endcase
        end

        // Search (re)start: shared by an accepted start and a relock.
        if (restart) begin
            state_d   = S_SETTLE;
            band_d    = 8'h80;
            bit_idx_d = 3'd7;
            verify_d  = 1'b0;
            settle_d  = '0;
            locked_d  = 1'b0;
            fail_d    = 1'b0;
            dlf_en_d  = 1'b0;
            busy_d    = 1'b1;
            smpl_d    = 2'b11;
            mtrx_d    = 2'b11;
`ifdef FLB_RELOCK_EN
            loss_d    = '0;
`endif
        end
    end

    always_ff @(posedge nsh_clk) begin
        if (rst) begin
            state        <= S_IDLE;
            band         <= 8'h80;
            bit_idx      <= 3'd7;
            verify       <= 1'b0;
            settle_cnt   <= '0;
            cnt          <= '0;
            meas_cnt     <= '0;
            tgt_q        <= '0;
            tol_q        <= '0;
            smpl_clk_lag <= 2'b11;
            mtrx_clk_lag <= 2'b11;
            dlf_en       <= 1'b0;
            busy         <= 1'b0;
            locked       <= 1'b0;
            fail         <= 1'b0;
`ifdef FLB_RELOCK_EN
            loss_cnt     <= '0;
`endif
        end else begin
            state        <= state_d;
            band         <= band_d;
            bit_idx      <= bit_idx_d;
            verify       <= verify_d;
            settle_cnt   <= settle_d;
            cnt          <= cnt_d;
            meas_cnt     <= meas_d;
            tgt_q        <= tgt_d;
            tol_q        <= tol_d;
            smpl_clk_lag <= smpl_d;
            mtrx_clk_lag <= mtrx_d;
            dlf_en       <= dlf_en_d;
            busy         <= busy_d;
            locked       <= locked_d;
            fail         <= fail_d;
`ifdef FLB_RELOCK_EN
            loss_cnt     <= loss_d;
`endif
        end
    end

endmodule
